apb_master_bridge: RTL
======================

# apb_master_bridge

Single-outstanding APB initiator that turns a simple valid/ready command port into APB SETUP/ACCESS transfers toward up to `NSLV` peripheral slaves (LED, GPIO, timer and similar). It decodes slave select from `cmd_addr[15:12]` and muxes the slaves' read data, ready and error back internally. It enforces an ACCESS-phase timeout and returns one response per command. It sits between the CPU-side bus fabric and the peripheral subsystem.

## Interface
- `NSLV`, 4: number of APB slaves, 1..16; slave n occupies `cmd_addr[15:12] == n`.
- `TIMEOUT`, 255: maximum ACCESS-phase cycles without `PREADY` before abort, 1..65535.

- `PCLK` in 1: clock.
- `PRESET` in 1: synchronous active-high reset; one clock, reset is synchronous and active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 16: byte address.
- `cmd_wdata` in 32: write data.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata` out 32: read data; 0 for writes and errors.
- `rsp_err` out 1: slave `PSLVERR`, decode error or timeout.
- `rsp_timeout` out 1: error was a timeout.
- `busy` out 1: state is not IDLE.
- `PADDR` out 16: APB address.
- `PSEL` out NSLV: one-hot slave select.
- `PENABLE` out 1: ACCESS phase.
- `PWRITE` out 1: APB direction.
- `PWDATA` out 32: write data; 0 during reads.
- `PRDATA_ALL` in 32*NSLV: slave n read data at bits `[32n+31:32n]`.
- `PREADY_ALL` in NSLV: per-slave ready.
- `PSLVERR_ALL` in NSLV: per-slave error.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `cmd_ready = 1`.
  - On handshake, latch write, address, wdata and index `idx = cmd_addr[15:12]`.
  - If `idx < NSLV`, go to SETUP.
  - Otherwise go to RESP with `rsp_err = 1`, `rsp_timeout = 0`, `rsp_rdata = 0`, and no APB activity.
- SETUP:
  - Drive `PSEL[idx] = 1`, `PENABLE = 0`, `PADDR`, `PWRITE`, `PWDATA` from the latch.
  - Always go to ACCESS next cycle.
  - Clear the timeout counter.
- ACCESS:
  - `PSEL[idx] = 1`, `PENABLE = 1`; address, control and data stay unchanged.
  - Each cycle with `PREADY_ALL[idx] = 0`, increment the counter.
  - If `PREADY_ALL[idx] = 1`:
    - Capture `rsp_err = PSLVERR_ALL[idx]`.
    - Capture `rsp_rdata`: `PRDATA_ALL[idx]` if it is a read and there is no error, else 0.
    - Go to RESP.
  - Else if the counter reaches `TIMEOUT`:
    - Set `rsp_err = 1`, `rsp_timeout = 1`, `rsp_rdata = 0`.
    - Go to RESP.
- RESP:
  - `rsp_valid = 1`; `PSEL` = 0 and `PENABLE` = 0.
  - Response fields stay stable until `rsp_ready`, then go to IDLE.
- Only `PREADY_ALL[idx]`, `PSLVERR_ALL[idx]` and `PRDATA_ALL[idx]` are observed; other slaves' inputs are ignored.
- Counter width is `$clog2(TIMEOUT+1)`; it saturates and never wraps.

## Timing
- Reset values (all outputs):
  - `cmd_ready = 0` during reset, 1 the first cycle after.
  - `rsp_valid`, `rsp_err`, `rsp_timeout`, `busy`, `PSEL`, `PENABLE`, `PWRITE` = 0.
  - `rsp_rdata`, `PADDR`, `PWDATA` = 0.
- Zero-wait transfer:
  - Handshake at edge 0.
  - SETUP in cycle 1, ACCESS in cycle 2 with `PREADY = 1`.
  - `rsp_valid` high in cycle 3.
  - If `rsp_ready` is already high, `cmd_ready` returns in cycle 4.
- Each `PREADY = 0` cycle in ACCESS adds one cycle of latency.
- Decode error: `rsp_valid` the cycle after the handshake.
- Timeout: `TIMEOUT` ACCESS cycles without ready, then RESP. ACCESS lasts exactly `TIMEOUT` cycles, and `PSEL` drops on the cycle after.
- If `PREADY` arrives on the same cycle the counter hits `TIMEOUT`, `PREADY` wins and the result is a normal completion.
- `cmd_ready` is low in SETUP, ACCESS and RESP; a `cmd_valid` held meanwhile is not accepted and must be held by the source.
- Reset mid-transfer:
  - `PRESET` high in any state forces IDLE on the next edge.
  - `PSEL` and `PENABLE` drop immediately.
  - Any pending response is discarded.
- `PSEL` is never multi-hot.
- `PENABLE` is never high without `PSEL`, and never high in the first cycle of `PSEL`.

## Test plan
- **Write, zero wait:** cmd write `addr = 0x1000`, `wdata = 0x000000A5`, `PREADY_ALL[1]` tied to 1.
  - Expect `PSEL = 4'b0010` for 2 cycles, `PENABLE` only in the 2nd, `PWDATA = 0xA5`.
  - Expect `rsp_valid` 3 cycles after the handshake with `rsp_err = 0`, `rsp_rdata = 0`.
- **Read with waits:** read `addr = 0x2004`; slave 2 holds `PREADY = 0` for 3 ACCESS cycles, then returns `0xDEADBEEF`.
  - Expect ACCESS for 4 cycles and `rsp_rdata = 0xDEADBEEF`, `rsp_err = 0`.
- **Slave error:** read from slave 0 with `PSLVERR = 1` when `PREADY = 1`.
  - Expect `rsp_err = 1`, `rsp_timeout = 0`, `rsp_rdata = 0`.
- **Decode error and backpressure:** `cmd_addr = 0x5000` with `NSLV = 4`.
  - Expect no `PSEL` activity and `rsp_valid` next cycle with `rsp_err = 1`.
  - Hold `rsp_ready = 0` for 5 cycles; response stays stable and `cmd_ready` stays 0.
- **Timeout and tie:**
  - `TIMEOUT = 8`, slave never ready: ACCESS lasts 8 cycles, then `rsp_err = 1`, `rsp_timeout = 1`.
  - Repeat with `PREADY` on the 8th ACCESS cycle: normal completion, `rsp_timeout = 0`.
- **Reset mid-transfer:** assert `PRESET` during ACCESS.
  - Next cycle: `PSEL = 0`, `PENABLE = 0`, `rsp_valid = 0`.
  - After release, a new read of slave 3 completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Brief    : Single-outstanding APB initiator that decodes the slave from
//            cmd_addr[15:12] and enforces an ACCESS-phase timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
    parameter int NSLV    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [15:0]          cmd_addr,
    input  logic [31:0]          cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic [15:0]          PADDR,
    output logic [NSLV-1:0]      PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [31:0]          PWDATA,
    input  logic [32*NSLV-1:0]   PRDATA_ALL,
    input  logic [NSLV-1:0]      PREADY_ALL,
    input  logic [NSLV-1:0]      PSLVERR_ALL
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] c_cnt_max  = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_write;
    logic [15:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_idx;
    logic [CW-1:0]      r_cnt;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic               r_tout;

    logic               w_hs;
    logic               w_dec_ok;
    logic               w_ready;
    logic               w_slverr;
    logic [31:0]        w_prdata;
    logic [NSLV-1:0]    w_sel;

    assign w_hs     = cmd_valid && cmd_ready;
    assign w_dec_ok = ({1'b0, cmd_addr[15:12]} < 5'(NSLV));

    // Only the addressed slave's ready/error/data are observed.
    always_comb begin
        w_ready  = 1'b0;
        w_slverr = 1'b0;
        w_prdata = '0;
        w_sel    = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (r_idx == 4'(i)) begin
                w_sel[i] = 1'b1;
                w_ready  = PREADY_ALL[i];
                w_slverr = PSLVERR_ALL[i];
                w_prdata = PRDATA_ALL[32*i +: 32];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Control outputs are masked by reset so the bus idles within the reset cycle.
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        PSEL      = '0;
        PENABLE   = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (w_hs) begin
                    w_next = w_dec_ok ? S_SETUP : S_RESP;
                end
            end
            S_SETUP: begin
                PSEL   = w_sel;
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                PSEL    = w_sel;
                PENABLE = 1'b1;
                if (w_ready || (r_cnt == c_cnt_last)) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (PRESET) begin
            cmd_ready = 1'b0;
            rsp_valid = 1'b0;
            PSEL      = '0;
            PENABLE   = 1'b0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_tout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_write <= cmd_write;
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_wdata;
                        r_idx   <= cmd_addr[15:12];
                        r_rdata <= '0;
                        r_err   <= !w_dec_ok;
                        r_tout  <= 1'b0;
                    end
                end
                S_SETUP: begin
                    r_cnt <= '0;
                end
                S_ACCESS: begin
                    if (w_ready) begin
                        r_err   <= w_slverr;
                        r_rdata <= (!r_write && !w_slverr) ? w_prdata : '0;
                    end else begin
                        if (r_cnt == c_cnt_last) begin
                            r_err   <= 1'b1;
                            r_tout  <= 1'b1;
                            r_rdata <= '0;
                        end
                        if (r_cnt != c_cnt_max) begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE) && !PRESET;
    assign rsp_rdata   = r_rdata;
    assign rsp_err     = r_err;
    assign rsp_timeout = r_tout;
    assign PADDR       = r_addr;
    assign PWRITE      = r_write;
    assign PWDATA      = r_write ? r_wdata : '0;

endmodule
`default_nettype wire
